id_ex_operand_stage: RTL and testbench

- Pipeline register between decode (ID) and execute (EX) for the 32-bit MIPS datapath.
- Captures decoded operands and control, and resolves operand forwarding from EX/MEM and MEM/WB.
- Drives ALUOperation, A, B and shamt straight into the ALU.
- Detects load-use hazards, stalling ID and inserting a bubble into EX.

---
 rtl/id_ex_operand_stage_pkg.sv | 39 +++
 rtl/id_ex_operand_stage_if.sv | 36 +++
 rtl/id_ex_operand_stage_forwarding_unit.sv | 36 +++
 rtl/id_ex_operand_stage.sv | 141 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU codes, forward selects
// and the control bundle that a pipeline bubble clears.
package id_ex_operand_stage_pkg;

  localparam int ID_EX_DATA_W = 32;
  localparam int ID_EX_REG_AW = 5;
  localparam int ID_EX_OP_W   = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_NOR = 4'd2,
    ALU_ADD = 4'd3,
    ALU_SUB = 4'd4,
    ALU_SRL = 4'd5,
    ALU_SLL = 4'd6,
    ALU_LUI = 4'd7,
    ALU_BEQ = 4'd8,
    ALU_BNE = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side bundle feeding the ID/EX stage; IdStall flows back to decode.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
);
  logic              IdValid;
  logic [DATA_W-1:0] IdReadData1;
  logic [DATA_W-1:0] IdReadData2;
  logic [DATA_W-1:0] IdImmediate;
  logic [REG_AW-1:0] IdRs;
  logic [REG_AW-1:0] IdRt;
  logic [REG_AW-1:0] IdWriteReg;
  logic [4:0]        IdShamt;
  logic [OP_W-1:0]   IdALUOperation;
  logic              IdALUSrc;
  logic              IdRegWrite;
  logic              IdMemRead;
  logic              IdMemWrite;
  logic              IdMemtoReg;
  logic              IdStall;

  modport master (
    output IdValid, IdReadData1, IdReadData2, IdImmediate, IdRs, IdRt,
           IdWriteReg, IdShamt, IdALUOperation, IdALUSrc, IdRegWrite,
           IdMemRead, IdMemWrite, IdMemtoReg,
    input  IdStall
  );

  modport slave (
    input  IdValid, IdReadData1, IdReadData2, IdImmediate, IdRs, IdRt,
           IdWriteReg, IdShamt, IdALUOperation, IdALUSrc, IdRegWrite,
           IdMemRead, IdMemWrite, IdMemtoReg,
    output IdStall
  );
endinterface

// File: rtl/id_ex_operand_stage_forwarding_unit.sv
// Combinational forward-select generation for the rs and rt operands.
module forwarding_unit
  import id_ex_operand_stage_pkg::*;
#(
  parameter int REG_AW = ID_EX_REG_AW
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              exmem_we_i,
  input  logic [REG_AW-1:0] exmem_wreg_i,
  input  logic              memwb_we_i,
  input  logic [REG_AW-1:0] memwb_wreg_i,
  input  logic              alusrc_i,
  output fwd_sel_e          sel_a_o,
  output fwd_sel_e          sel_rt_o,
  output logic              b_imm_o
);

  // EX/MEM is the younger result, so it wins; r0 is never a forwarding target.
  function automatic fwd_sel_e pick(
    input logic [REG_AW-1:0] r,
    input logic              em_we,
    input logic [REG_AW-1:0] em_wr,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_wr
  );
    if (em_we && (em_wr != '0) && (em_wr == r))      return FWD_EXMEM;
    else if (mw_we && (mw_wr != '0) && (mw_wr == r)) return FWD_MEMWB;
    else                                             return FWD_REG;
  endfunction

  assign sel_a_o  = pick(rs_i, exmem_we_i, exmem_wreg_i, memwb_we_i, memwb_wreg_i);
  assign sel_rt_o = pick(rt_i, exmem_we_i, exmem_wreg_i, memwb_we_i, memwb_wreg_i);
  assign b_imm_o  = alusrc_i;

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard stall.
// Optional BubbleCount output enabled by ID_EX_BUBBLE_COUNT_EN.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int REG_AW = ID_EX_REG_AW,
  parameter int OP_W   = ID_EX_OP_W
) (
  input  logic              clk,
  input  logic              reset,
  id_ex_operand_stage_if.slave id,
  input  logic              ExStall,
  input  logic              Flush,
  input  logic              ExMemRegWrite,
  input  logic [REG_AW-1:0] ExMemWriteReg,
  input  logic [DATA_W-1:0] ExMemALUResult,
  input  logic              MemWbRegWrite,
  input  logic [REG_AW-1:0] MemWbWriteReg,
  input  logic [DATA_W-1:0] MemWbWriteData,
  output logic [OP_W-1:0]   ALUOperation,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [4:0]        shamt,
  output logic [DATA_W-1:0] ExStoreData,
  output logic              ExValid,
  output logic              ExRegWrite,
  output logic              ExMemRead,
  output logic              ExMemWrite,
  output logic              ExMemtoReg,
`ifdef ID_EX_BUBBLE_COUNT_EN
  output logic [15:0]       BubbleCount,
`endif
  output logic [REG_AW-1:0] ExWriteReg
);

  ctrl_t             ctrl_q;
  logic [OP_W-1:0]   aluop_q;
  logic [REG_AW-1:0] wreg_q, rs_q, rt_q;
  logic [4:0]        shamt_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;

  logic     load_use, load_bubble, capture, b_imm;
  fwd_sel_e sel_a, sel_rt;
  logic [DATA_W-1:0] a_fwd, rt_fwd;

  assign load_use = ctrl_q.valid && ctrl_q.mem_read && (wreg_q != '0) && id.IdValid &&
                    ((wreg_q == id.IdRs) || (wreg_q == id.IdRt));
  assign id.IdStall = load_use | ExStall;

  // Flush overrides a hold; a load-use bubble only loads when not held.
  assign load_bubble = Flush | (~ExStall & load_use);
  assign capture     = ~Flush & ~ExStall & ~load_use;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= BUBBLE_CTRL;
      aluop_q <= '0;
      wreg_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      shamt_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
    end else if (load_bubble) begin
      ctrl_q  <= BUBBLE_CTRL;
      aluop_q <= '0;
      wreg_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      shamt_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
    end else if (capture) begin
      ctrl_q  <= '{valid: id.IdValid, reg_write: id.IdRegWrite, mem_read: id.IdMemRead,
                   mem_write: id.IdMemWrite, mem_to_reg: id.IdMemtoReg, alu_src: id.IdALUSrc};
      aluop_q <= id.IdALUOperation;
      wreg_q  <= id.IdWriteReg;
      rs_q    <= id.IdRs;
      rt_q    <= id.IdRt;
      shamt_q <= id.IdShamt;
      rd1_q   <= id.IdReadData1;
      rd2_q   <= id.IdReadData2;
      imm_q   <= id.IdImmediate;
    end
  end

  forwarding_unit #(.REG_AW(REG_AW)) u_fwd (
    .rs_i         (rs_q),
    .rt_i         (rt_q),
    .exmem_we_i   (ExMemRegWrite),
    .exmem_wreg_i (ExMemWriteReg),
    .memwb_we_i   (MemWbRegWrite),
    .memwb_wreg_i (MemWbWriteReg),
    .alusrc_i     (ctrl_q.alu_src),
    .sel_a_o      (sel_a),
    .sel_rt_o     (sel_rt),
    .b_imm_o      (b_imm)
  );

  always_comb begin
    a_fwd = rd1_q;
    case (sel_a)
      FWD_EXMEM: a_fwd = ExMemALUResult;
      FWD_MEMWB: a_fwd = MemWbWriteData;
      default:   a_fwd = rd1_q;
    endcase
    rt_fwd = rd2_q;
    case (sel_rt)
      FWD_EXMEM: rt_fwd = ExMemALUResult;
      FWD_MEMWB: rt_fwd = MemWbWriteData;
      default:   rt_fwd = rd2_q;
    endcase
  end

  assign A            = a_fwd;
  assign B            = b_imm ? imm_q : rt_fwd;
  assign ExStoreData  = rt_fwd;
  assign ALUOperation = aluop_q;
  assign shamt        = shamt_q;
  assign ExValid      = ctrl_q.valid;
  assign ExRegWrite   = ctrl_q.reg_write;
  assign ExMemRead    = ctrl_q.mem_read;
  assign ExMemWrite   = ctrl_q.mem_write;
  assign ExMemtoReg   = ctrl_q.mem_to_reg;
  assign ExWriteReg   = wreg_q;

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] bubble_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                         bubble_cnt_q <= '0;
    else if (load_bubble && (bubble_cnt_q != 16'hFFFF)) bubble_cnt_q <= bubble_cnt_q + 16'd1;
  end

  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus random
// traffic compared against a behavioural model of the EX stage contents.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ExStall, Flush;
  logic        ExMemRegWrite, MemWbRegWrite;
  logic [4:0]  ExMemWriteReg, MemWbWriteReg;
  logic [31:0] ExMemALUResult, MemWbWriteData;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B, ExStoreData;
  logic [4:0]  shamt, ExWriteReg;
  logic        ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemtoReg;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] BubbleCount;
`endif

  id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5), .OP_W(4)) bus ();

  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5), .OP_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .id             (bus.slave),
    .ExStall        (ExStall),
    .Flush          (Flush),
    .ExMemRegWrite  (ExMemRegWrite),
    .ExMemWriteReg  (ExMemWriteReg),
    .ExMemALUResult (ExMemALUResult),
    .MemWbRegWrite  (MemWbRegWrite),
    .MemWbWriteReg  (MemWbWriteReg),
    .MemWbWriteData (MemWbWriteData),
    .ALUOperation   (ALUOperation),
    .A              (A),
    .B              (B),
    .shamt          (shamt),
    .ExStoreData    (ExStoreData),
    .ExValid        (ExValid),
    .ExRegWrite     (ExRegWrite),
    .ExMemRead      (ExMemRead),
    .ExMemWrite     (ExMemWrite),
    .ExMemtoReg     (ExMemtoReg),
`ifdef ID_EX_BUBBLE_COUNT_EN
    .BubbleCount    (BubbleCount),
`endif
    .ExWriteReg     (ExWriteReg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: what instruction currently sits in EX (all-zero means empty/bubble).
  typedef struct {
    bit        v, rw, mr, mw, m2r, src;
    bit [3:0]  op;
    bit [4:0]  wr, rs, rt, sh;
    bit [31:0] d1, d2, imm;
  } ex_t;

  ex_t         m;
  int unsigned m_bubbles;

  function automatic ex_t empty_ex();
    ex_t e;
    e = '{v:0, rw:0, mr:0, mw:0, m2r:0, src:0, op:0, wr:0, rs:0, rt:0, sh:0, d1:0, d2:0, imm:0};
    return e;
  endfunction

  function automatic bit [31:0] fwd_value(input bit [4:0] r, input bit [31:0] own);
    if (ExMemRegWrite && ExMemWriteReg != 0 && ExMemWriteReg == r) return ExMemALUResult;
    if (MemWbRegWrite && MemWbWriteReg != 0 && MemWbWriteReg == r) return MemWbWriteData;
    return own;
  endfunction

  function automatic bit model_load_use();
    return m.v && m.mr && m.wr != 0 && bus.IdValid &&
           (m.wr == bus.IdRs || m.wr == bus.IdRt);
  endfunction

  task automatic check_all();
    bit [31:0] rt_val;
    rt_val = fwd_value(m.rt, m.d2);
    check("IdStall", 32'(bus.IdStall), 32'(model_load_use() || ExStall));
    check("ExValid", 32'(ExValid), 32'(m.v));
    check("ExRegWrite", 32'(ExRegWrite), 32'(m.rw));
    check("ExMemRead", 32'(ExMemRead), 32'(m.mr));
    check("ExMemWrite", 32'(ExMemWrite), 32'(m.mw));
    check("ExMemtoReg", 32'(ExMemtoReg), 32'(m.m2r));
    check("ALUOperation", 32'(ALUOperation), 32'(m.op));
    check("ExWriteReg", 32'(ExWriteReg), 32'(m.wr));
    check("shamt", 32'(shamt), 32'(m.sh));
    check("A", A, fwd_value(m.rs, m.d1));
    check("B", B, m.src ? m.imm : rt_val);
    check("ExStoreData", ExStoreData, rt_val);
`ifdef ID_EX_BUBBLE_COUNT_EN
    check("BubbleCount", 32'(BubbleCount), (m_bubbles > 32'hFFFF) ? 32'hFFFF : m_bubbles);
`endif
  endtask

  task automatic model_step();
    if (Flush) begin
      m = empty_ex(); m_bubbles++;
    end else if (ExStall) begin
      // hold
    end else if (model_load_use()) begin
      m = empty_ex(); m_bubbles++;
    end else begin
      m.v = bus.IdValid;    m.rw = bus.IdRegWrite; m.mr = bus.IdMemRead;
      m.mw = bus.IdMemWrite; m.m2r = bus.IdMemtoReg; m.src = bus.IdALUSrc;
      m.op = bus.IdALUOperation; m.wr = bus.IdWriteReg; m.rs = bus.IdRs;
      m.rt = bus.IdRt; m.sh = bus.IdShamt; m.d1 = bus.IdReadData1;
      m.d2 = bus.IdReadData2; m.imm = bus.IdImmediate;
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.IdValid = 0; bus.IdReadData1 = 0; bus.IdReadData2 = 0; bus.IdImmediate = 0;
    bus.IdRs = 0; bus.IdRt = 0; bus.IdWriteReg = 0; bus.IdShamt = 0;
    bus.IdALUOperation = 0; bus.IdALUSrc = 0; bus.IdRegWrite = 0;
    bus.IdMemRead = 0; bus.IdMemWrite = 0; bus.IdMemtoReg = 0;
    ExStall = 0; Flush = 0;
    ExMemRegWrite = 0; ExMemWriteReg = 0; ExMemALUResult = 0;
    MemWbRegWrite = 0; MemWbWriteReg = 0; MemWbWriteData = 0;
  endtask

  task automatic drive_add(input bit [4:0] rs, input bit [4:0] rt,
                           input bit [31:0] d1, input bit [31:0] d2);
    bus.IdValid = 1; bus.IdALUOperation = ALU_ADD; bus.IdRegWrite = 1;
    bus.IdRs = rs; bus.IdRt = rt; bus.IdWriteReg = 5'd10;
    bus.IdReadData1 = d1; bus.IdReadData2 = d2;
  endtask

  task automatic randomize_inputs();
    bus.IdValid        = ($urandom_range(0, 3) != 0);
    bus.IdReadData1    = $urandom;
    bus.IdReadData2    = $urandom;
    bus.IdImmediate    = $urandom;
    bus.IdRs           = 5'($urandom_range(0, 3));
    bus.IdRt           = 5'($urandom_range(0, 3));
    bus.IdWriteReg     = 5'($urandom_range(0, 3));
    bus.IdShamt        = 5'($urandom);
    bus.IdALUOperation = 4'($urandom_range(0, 9));
    bus.IdALUSrc       = 1'($urandom);
    bus.IdRegWrite     = 1'($urandom);
    bus.IdMemRead      = ($urandom_range(0, 2) == 0);
    bus.IdMemWrite     = 1'($urandom);
    bus.IdMemtoReg     = 1'($urandom);
    ExStall            = ($urandom_range(0, 4) == 0);
    Flush              = ($urandom_range(0, 7) == 0);
    ExMemRegWrite      = 1'($urandom);
    ExMemWriteReg      = 5'($urandom_range(0, 3));
    ExMemALUResult     = $urandom;
    MemWbRegWrite      = 1'($urandom);
    MemWbWriteReg      = 5'($urandom_range(0, 3));
    MemWbWriteData     = $urandom;
  endtask

  initial begin
    m = empty_ex();
    m_bubbles = 0;
    set_idle();
    reset = 0;
    #2;
    check_all();
    #10 reset = 1;
    @(posedge clk); #1;

    // Reset mid-stream
    drive_add(5'd8, 5'd9, 32'd5, 32'd7);
    cycle();
    #1 check("pre_reset_A", A, 32'd5);
    #2 reset = 0;
    #1;
    m = empty_ex(); m_bubbles = 0;
    check("reset_ExValid", 32'(ExValid), 32'd0);
    check("reset_A", A, 32'd0);
    check("reset_B", B, 32'd0);
    check_all();
    set_idle();
    #1 reset = 1;
    @(posedge clk); #1;

    // Load-use: EX holds lw r9, ID reads r9
    bus.IdValid = 1; bus.IdMemRead = 1; bus.IdRegWrite = 1; bus.IdMemtoReg = 1;
    bus.IdWriteReg = 5'd9; bus.IdALUOperation = ALU_ADD;
    cycle();
    set_idle();
    drive_add(5'd3, 5'd9, 32'd11, 32'd22);
    #1 check("lu_IdStall", 32'(bus.IdStall), 32'd1);
    cycle();
    check("lu_bubble_ExValid", 32'(ExValid), 32'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    check("lu_BubbleCount", 32'(BubbleCount), 32'd1);
`endif
    cycle();
    check("lu_captured_ExValid", 32'(ExValid), 32'd1);
    check("lu_captured_A", A, 32'd11);

    // Plain capture
    set_idle();
    drive_add(5'd8, 5'd9, 32'd5, 32'd7);
    cycle();
    set_idle();
    ExStall = 1;
    #1;
    check("plain_op", 32'(ALUOperation), 32'd3);
    check("plain_A", A, 32'd5);
    check("plain_B", B, 32'd7);

    // Double forward while held
    ExMemRegWrite = 1; ExMemWriteReg = 5'd8; ExMemALUResult = 32'd100;
    MemWbRegWrite = 1; MemWbWriteReg = 5'd8; MemWbWriteData = 32'd50;
    #1 check("fwd_exmem_A", A, 32'd100);
    ExMemRegWrite = 0;
    #1 check("fwd_memwb_A", A, 32'd50);
    ExMemRegWrite = 1; ExMemWriteReg = 5'd0; ExMemALUResult = 32'd99;
    MemWbRegWrite = 0;
    #1 check("fwd_r0_A", A, 32'd5);
    cycle();

    // Flush while stalled
    set_idle();
    drive_add(5'd1, 5'd2, 32'd3, 32'd4);
    cycle();
    check("pre_flush_ExValid", 32'(ExValid), 32'd1);
    Flush = 1; ExStall = 1;
    cycle();
    check("flush_ExValid", 32'(ExValid), 32'd0);
    check("flush_ExRegWrite", 32'(ExRegWrite), 32'd0);

    // ALUSrc with store data forwarded from MEM/WB
    set_idle();
    bus.IdValid = 1; bus.IdALUSrc = 1; bus.IdImmediate = 32'hFFFF_FFFC;
    bus.IdRt = 5'd5; bus.IdReadData2 = 32'd7; bus.IdMemWrite = 1;
    bus.IdALUOperation = ALU_ADD;
    cycle();
    set_idle();
    ExStall = 1;
    MemWbRegWrite = 1; MemWbWriteReg = 5'd5; MemWbWriteData = 32'h1234;
    #1;
    check("alusrc_B", B, 32'hFFFF_FFFC);
    check("store_data", ExStoreData, 32'h1234);
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle();
    end
    #1 check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
